// File: rtl/riscv_pkg.sv
// Shared RV32I decode definitions: opcodes, instruction field positions,
// immediate format selector and the per-opcode control lookup.
package riscv_pkg;

    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;

    localparam int OPC_LSB = 0;
    localparam int OPC_MSB = 6;
    localparam int RD_LSB  = 7;
    localparam int RD_MSB  = 11;
    localparam int RS1_LSB = 15;
    localparam int RS1_MSB = 19;
    localparam int RS2_LSB = 20;
    localparam int RS2_MSB = 24;

    typedef enum logic [2:0] {
        IMM_I,
        IMM_S,
        IMM_B,
        IMM_U,
        IMM_J,
        IMM_NONE
    } imm_type_e;

    typedef enum logic {
        SLOT_EMPTY,
        SLOT_FULL
    } slot_state_e;

    typedef struct packed {
        logic      use_rs1;
        logic      use_rs2;
        logic      has_rd;
        imm_type_e imm_type;
        logic      illegal;
    } dec_ctrl_t;

    // Unknown opcodes claim both sources so a pending load still stalls them.
    function automatic dec_ctrl_t decode_ctrl(input logic [6:0] opcode);
        dec_ctrl_t ctrl;
        case (opcode)
            OPC_LUI:    ctrl = '{1'b0, 1'b0, 1'b1, IMM_U,    1'b0};
            OPC_AUIPC:  ctrl = '{1'b0, 1'b0, 1'b1, IMM_U,    1'b0};
            OPC_JAL:    ctrl = '{1'b0, 1'b0, 1'b1, IMM_J,    1'b0};
            OPC_JALR:   ctrl = '{1'b1, 1'b0, 1'b1, IMM_I,    1'b0};
            OPC_LOAD:   ctrl = '{1'b1, 1'b0, 1'b1, IMM_I,    1'b0};
            OPC_OP_IMM: ctrl = '{1'b1, 1'b0, 1'b1, IMM_I,    1'b0};
            OPC_BRANCH: ctrl = '{1'b1, 1'b1, 1'b0, IMM_B,    1'b0};
            OPC_STORE:  ctrl = '{1'b1, 1'b1, 1'b0, IMM_S,    1'b0};
            OPC_OP:     ctrl = '{1'b1, 1'b1, 1'b1, IMM_NONE, 1'b0};
            default:    ctrl = '{1'b1, 1'b1, 1'b0, IMM_NONE, 1'b1};
        endcase
        return ctrl;
    endfunction

endpackage

// File: rtl/decode_stage_if.sv
// Fetch-beat input and ID/EX output handshakes of the decode stage.
// master is the surrounding pipeline, slave is the decode stage itself.
interface decode_stage_if #(
    parameter int XLEN       = 32,
    parameter int ADDR_WIDTH = 5
);
    logic                  if_valid_i;
    logic                  if_ready_o;
    logic [31:0]           if_instr_i;
    logic [XLEN-1:0]       if_pc_i;
    logic                  id_valid_o;
    logic                  id_ready_i;
    logic [XLEN-1:0]       id_pc_o;
    logic [31:0]           id_instr_o;
    logic [XLEN-1:0]       id_op_a_o;
    logic [XLEN-1:0]       id_op_b_o;
    logic [XLEN-1:0]       id_imm_o;
    logic [ADDR_WIDTH-1:0] id_rd_o;
    logic                  id_rd_we_o;
    logic                  id_illegal_o;

    modport master (
        output if_valid_i, if_instr_i, if_pc_i, id_ready_i,
        input  if_ready_o, id_valid_o, id_pc_o, id_instr_o, id_op_a_o,
               id_op_b_o, id_imm_o, id_rd_o, id_rd_we_o, id_illegal_o
    );

    modport slave (
        input  if_valid_i, if_instr_i, if_pc_i, id_ready_i,
        output if_ready_o, id_valid_o, id_pc_o, id_instr_o, id_op_a_o,
               id_op_b_o, id_imm_o, id_rd_o, id_rd_we_o, id_illegal_o
    );
endinterface

// File: rtl/imm_gen.sv
// Combinational RV32I immediate generator; all formats sign-extend from instr[31].
module imm_gen
    import riscv_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [31:0]     instr,
    input  imm_type_e       imm_type,
    output logic [XLEN-1:0] imm
);

    logic [31:0] imm32_s;
    logic        unused_opcode_s;

    assign unused_opcode_s = ^instr[6:0];

    // Assemble the 32-bit immediate for the selected format.
    always_comb begin
        imm32_s = 32'd0;
        case (imm_type)
            IMM_I:   imm32_s = {{20{instr[31]}}, instr[31:20]};
            IMM_S:   imm32_s = {{20{instr[31]}}, instr[31:25], instr[11:7]};
            IMM_B:   imm32_s = {{19{instr[31]}}, instr[31], instr[7], instr[30:25],
                                instr[11:8], 1'b0};
            IMM_U:   imm32_s = {instr[31:12], 12'd0};
            IMM_J:   imm32_s = {{11{instr[31]}}, instr[31], instr[19:12], instr[20],
                                instr[30:21], 1'b0};
            default: imm32_s = 32'd0;
        endcase
    end

    assign imm = XLEN'($signed(imm32_s));

endmodule

// File: rtl/decode_stage.sv
// RV32I decode / operand-fetch stage: one-entry IF/ID slot, EX/WB bypass,
// load-use stall and the registered ID/EX pipeline register.
module decode_stage
    import riscv_pkg::*;
#(
    parameter int XLEN       = 32,
    parameter int ADDR_WIDTH = 5
) (
    input  logic                  clk,
    input  logic                  rst,
    decode_stage_if.slave         bus,
    output logic [ADDR_WIDTH-1:0] rf_raddr_a_o,
    output logic [ADDR_WIDTH-1:0] rf_raddr_b_o,
    input  logic [XLEN-1:0]       rf_rdata_a_i,
    input  logic [XLEN-1:0]       rf_rdata_b_i,
    input  logic                  ex_we_i,
    input  logic [ADDR_WIDTH-1:0] ex_waddr_i,
    input  logic [XLEN-1:0]       ex_wdata_i,
    input  logic                  ex_is_load_i,
    input  logic                  wb_we_i,
    input  logic [ADDR_WIDTH-1:0] wb_waddr_i,
    input  logic [XLEN-1:0]       wb_wdata_i,
    input  logic                  flush_i
);

    slot_state_e           state_r;
    slot_state_e           state_n;
    logic [31:0]           slot_instr_r;
    logic [XLEN-1:0]       slot_pc_r;

    logic                  slot_valid_s;
    logic                  hazard_s;
    logic                  advance_s;
    logic                  if_ready_s;
    logic                  load_s;
    logic                  rs1_hit_s;
    logic                  rs2_hit_s;
    logic                  rd_we_s;
    dec_ctrl_t             ctrl_s;
    logic [ADDR_WIDTH-1:0] rs1_s;
    logic [ADDR_WIDTH-1:0] rs2_s;
    logic [ADDR_WIDTH-1:0] rd_s;
    logic [XLEN-1:0]       imm_s;
    logic [XLEN-1:0]       op_a_s;
    logic [XLEN-1:0]       op_b_s;

    logic                  id_valid_r;
    logic [XLEN-1:0]       id_pc_r;
    logic [31:0]           id_instr_r;
    logic [XLEN-1:0]       id_op_a_r;
    logic [XLEN-1:0]       id_op_b_r;
    logic [XLEN-1:0]       id_imm_r;
    logic [ADDR_WIDTH-1:0] id_rd_r;
    logic                  id_rd_we_r;
    logic                  id_illegal_r;

    // EX beats WB; a WB write lands in the register file only at the edge.
    function automatic logic [XLEN-1:0] resolve_operand(
        input logic [ADDR_WIDTH-1:0] idx,
        input logic [XLEN-1:0]       rf_data,
        input logic                  ex_we,
        input logic [ADDR_WIDTH-1:0] ex_waddr,
        input logic [XLEN-1:0]       ex_wdata,
        input logic                  ex_is_load,
        input logic                  wb_we,
        input logic [ADDR_WIDTH-1:0] wb_waddr,
        input logic [XLEN-1:0]       wb_wdata
    );
        logic [XLEN-1:0] val;
        if (idx == {ADDR_WIDTH{1'b0}}) begin
            val = {XLEN{1'b0}};
        end else if (ex_we && (ex_waddr == idx) && !ex_is_load) begin
            val = ex_wdata;
        end else if (wb_we && (wb_waddr == idx)) begin
            val = wb_wdata;
        end else begin
            val = rf_data;
        end
        return val;
    endfunction

    assign slot_valid_s = (state_r == SLOT_FULL);
    assign ctrl_s       = decode_ctrl(slot_instr_r[OPC_MSB:OPC_LSB]);
    assign rs1_s        = slot_instr_r[RS1_MSB:RS1_LSB];
    assign rs2_s        = slot_instr_r[RS2_MSB:RS2_LSB];
    assign rd_s         = slot_instr_r[RD_MSB:RD_LSB];
    assign rd_we_s      = ctrl_s.has_rd && (rd_s != {ADDR_WIDTH{1'b0}});
    assign rf_raddr_a_o = rs1_s;
    assign rf_raddr_b_o = rs2_s;

    imm_gen #(.XLEN(XLEN)) u_imm_gen (
        .instr    (slot_instr_r),
        .imm_type (ctrl_s.imm_type),
        .imm      (imm_s)
    );

    assign op_a_s = resolve_operand(rs1_s, rf_rdata_a_i, ex_we_i, ex_waddr_i, ex_wdata_i,
                                    ex_is_load_i, wb_we_i, wb_waddr_i, wb_wdata_i);
    assign op_b_s = resolve_operand(rs2_s, rf_rdata_b_i, ex_we_i, ex_waddr_i, ex_wdata_i,
                                    ex_is_load_i, wb_we_i, wb_waddr_i, wb_wdata_i);

    // Load-use detection against the sources this opcode actually reads.
    always_comb begin
        rs1_hit_s = ctrl_s.use_rs1 && (ex_waddr_i == rs1_s);
        rs2_hit_s = ctrl_s.use_rs2 && (ex_waddr_i == rs2_s);
        hazard_s  = slot_valid_s && ex_we_i && ex_is_load_i &&
                    (ex_waddr_i != {ADDR_WIDTH{1'b0}}) && (rs1_hit_s || rs2_hit_s);
    end

    assign advance_s      = slot_valid_s && !hazard_s && (!id_valid_r || bus.id_ready_i);
    assign if_ready_s     = !slot_valid_s || advance_s;
    assign load_s         = bus.if_valid_i && if_ready_s && !flush_i;
    assign bus.if_ready_o = if_ready_s;

    // Slot occupancy next-state; flush empties the slot and drops the incoming beat.
    always_comb begin
        state_n = state_r;
        case (state_r)
            SLOT_EMPTY: begin
                if (load_s) begin
                    state_n = SLOT_FULL;
                end else begin
                    state_n = SLOT_EMPTY;
                end
            end
            SLOT_FULL: begin
                if (flush_i) begin
                    state_n = SLOT_EMPTY;
                end else if (load_s) begin
                    state_n = SLOT_FULL;
                end else if (advance_s) begin
                    state_n = SLOT_EMPTY;
                end else begin
                    state_n = SLOT_FULL;
                end
            end
            default: state_n = SLOT_EMPTY;
        endcase
    end

    // Slot occupancy state register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= SLOT_EMPTY;
        end else begin
            state_r <= state_n;
        end
    end

    // Slot payload capture.
    always_ff @(posedge clk) begin
        if (rst) begin
            slot_instr_r <= 32'd0;
            slot_pc_r    <= {XLEN{1'b0}};
        end else if (load_s) begin
            slot_instr_r <= bus.if_instr_i;
            slot_pc_r    <= bus.if_pc_i;
        end
    end

    // ID/EX register: load on advance, bubble when drained, hold under backpressure.
    always_ff @(posedge clk) begin
        if (rst) begin
            id_valid_r   <= 1'b0;
            id_pc_r      <= {XLEN{1'b0}};
            id_instr_r   <= 32'd0;
            id_op_a_r    <= {XLEN{1'b0}};
            id_op_b_r    <= {XLEN{1'b0}};
            id_imm_r     <= {XLEN{1'b0}};
            id_rd_r      <= {ADDR_WIDTH{1'b0}};
            id_rd_we_r   <= 1'b0;
            id_illegal_r <= 1'b0;
        end else if (flush_i) begin
            id_valid_r   <= 1'b0;
        end else if (advance_s) begin
            id_valid_r   <= 1'b1;
            id_pc_r      <= slot_pc_r;
            id_instr_r   <= slot_instr_r;
            id_op_a_r    <= op_a_s;
            id_op_b_r    <= op_b_s;
            id_imm_r     <= imm_s;
            id_rd_r      <= rd_s;
            id_rd_we_r   <= rd_we_s;
            id_illegal_r <= ctrl_s.illegal;
        end else if (bus.id_ready_i) begin
            id_valid_r   <= 1'b0;
        end
    end

    assign bus.id_valid_o   = id_valid_r;
    assign bus.id_pc_o      = id_pc_r;
    assign bus.id_instr_o   = id_instr_r;
    assign bus.id_op_a_o    = id_op_a_r;
    assign bus.id_op_b_o    = id_op_b_r;
    assign bus.id_imm_o     = id_imm_r;
    assign bus.id_rd_o      = id_rd_r;
    assign bus.id_rd_we_o   = id_rd_we_r;
    assign bus.id_illegal_o = id_illegal_r;

endmodule

// File: tb/tb_decode_stage.sv
// Scoreboard bench for decode_stage: directed beats push hand-computed ID/EX
// contents; a negedge monitor pops and compares on every ID/EX handshake.
module tb_decode_stage;

    logic        clk = 1'b0;
    logic        rst;
    logic [4:0]  rf_raddr_a, rf_raddr_b;
    logic [31:0] rf_rdata_a, rf_rdata_b;
    logic        ex_we, ex_is_load, wb_we, flush;
    logic [4:0]  ex_waddr, wb_waddr;
    logic [31:0] ex_wdata, wb_wdata;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] instr;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] imm;
        logic [4:0]  rd;
        logic        we;
        logic        ill;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;

    decode_stage_if #(.XLEN(32), .ADDR_WIDTH(5)) bus ();

    decode_stage #(.XLEN(32), .ADDR_WIDTH(5)) dut (
        .clk          (clk),
        .rst          (rst),
        .bus          (bus),
        .rf_raddr_a_o (rf_raddr_a),
        .rf_raddr_b_o (rf_raddr_b),
        .rf_rdata_a_i (rf_rdata_a),
        .rf_rdata_b_i (rf_rdata_b),
        .ex_we_i      (ex_we),
        .ex_waddr_i   (ex_waddr),
        .ex_wdata_i   (ex_wdata),
        .ex_is_load_i (ex_is_load),
        .wb_we_i      (wb_we),
        .wb_waddr_i   (wb_waddr),
        .wb_wdata_i   (wb_wdata),
        .flush_i      (flush)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_ctx();
        ex_we = 1'b0; ex_waddr = 5'd0; ex_wdata = 32'd0; ex_is_load = 1'b0;
        wb_we = 1'b0; wb_waddr = 5'd0; wb_wdata = 32'd0;
        rf_rdata_a = 32'd0; rf_rdata_b = 32'd0;
    endtask

    task automatic push(input logic [31:0] pc, input logic [31:0] instr, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] imm, input logic [4:0] rd,
                        input logic we, input logic ill);
        exp_t e;
        e.pc = pc; e.instr = instr; e.a = a; e.b = b; e.imm = imm;
        e.rd = rd; e.we = we; e.ill = ill;
        sb.push_back(e);
    endtask

    // Present one beat for a cycle; it must be accepted into the empty slot.
    task automatic send(input logic [31:0] instr, input logic [31:0] pc);
        bus.if_valid_i = 1'b1;
        bus.if_instr_i = instr;
        bus.if_pc_i    = pc;
        #1;
        check("send_if_ready", {31'd0, bus.if_ready_o}, 32'd1);
        tick();
        bus.if_valid_i = 1'b0;
    endtask

    // Monitor: every ID/EX handshake must match the oldest expected entry.
    always @(negedge clk) begin
        if (!rst && bus.id_valid_o && bus.id_ready_i) begin
            if (sb.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_issue pc=%h expected no issue", bus.id_pc_o);
            end else begin
                mon_e = sb.pop_front();
                check("id_pc",      bus.id_pc_o,              mon_e.pc);
                check("id_instr",   bus.id_instr_o,           mon_e.instr);
                check("id_op_a",    bus.id_op_a_o,            mon_e.a);
                check("id_op_b",    bus.id_op_b_o,            mon_e.b);
                check("id_imm",     bus.id_imm_o,             mon_e.imm);
                check("id_rd",      {27'd0, bus.id_rd_o},     {27'd0, mon_e.rd});
                check("id_rd_we",   {31'd0, bus.id_rd_we_o},  {31'd0, mon_e.we});
                check("id_illegal", {31'd0, bus.id_illegal_o}, {31'd0, mon_e.ill});
            end
        end
    end

    initial begin
        rst = 1'b1;
        flush = 1'b0;
        bus.if_valid_i = 1'b0;
        bus.if_instr_i = 32'd0;
        bus.if_pc_i    = 32'd0;
        bus.id_ready_i = 1'b1;
        clear_ctx();
        tick();
        tick();
        check("rst_id_valid", {31'd0, bus.id_valid_o}, 32'd0);
        check("rst_if_ready", {31'd0, bus.if_ready_o}, 32'd1);
        check("rst_id_pc",    bus.id_pc_o,   32'd0);
        check("rst_id_imm",   bus.id_imm_o,  32'd0);
        check("rst_id_op_a",  bus.id_op_a_o, 32'd0);
        rst = 1'b0;

        // ADDI x1,x0,5: visible one edge after acceptance
        send(32'h0050_0093, 32'h100);
        push(32'h100, 32'h0050_0093, 32'd0, 32'd0, 32'd5, 5'd1, 1'b1, 1'b0);
        tick();
        check("latency_id_valid", {31'd0, bus.id_valid_o}, 32'd1);

        // ADD x3,x1,x2: EX wins over WB on rs1, rs2 from register file
        send(32'h0020_81B3, 32'h104);
        ex_we = 1'b1; ex_waddr = 5'd1; ex_wdata = 32'hAA;
        wb_we = 1'b1; wb_waddr = 5'd1; wb_wdata = 32'hBB;
        rf_rdata_a = 32'h11; rf_rdata_b = 32'h22;
        #1;
        check("rf_raddr_a", {27'd0, rf_raddr_a}, 32'd1);
        check("rf_raddr_b", {27'd0, rf_raddr_b}, 32'd2);
        push(32'h104, 32'h0020_81B3, 32'hAA, 32'h22, 32'd0, 5'd3, 1'b1, 1'b0);
        tick();
        clear_ctx();

        // ADD x3,x1,x2: WB bypass on rs2, unrelated EX write
        send(32'h0020_81B3, 32'h108);
        ex_we = 1'b1; ex_waddr = 5'd5; ex_wdata = 32'h99;
        wb_we = 1'b1; wb_waddr = 5'd2; wb_wdata = 32'hBB;
        rf_rdata_a = 32'h11; rf_rdata_b = 32'h22;
        push(32'h108, 32'h0020_81B3, 32'h11, 32'hBB, 32'd0, 5'd3, 1'b1, 1'b0);
        tick();
        clear_ctx();

        // Load-use on x2: one stall cycle, then WB supplies the loaded value
        send(32'h0020_81B3, 32'h10C);
        ex_we = 1'b1; ex_is_load = 1'b1; ex_waddr = 5'd2; ex_wdata = 32'hDEAD;
        rf_rdata_a = 32'h11; rf_rdata_b = 32'h22;
        #1;
        check("hazard_if_ready", {31'd0, bus.if_ready_o}, 32'd0);
        tick();
        check("hazard_bubble", {31'd0, bus.id_valid_o}, 32'd0);
        ex_we = 1'b0; ex_is_load = 1'b0; ex_waddr = 5'd0;
        wb_we = 1'b1; wb_waddr = 5'd2; wb_wdata = 32'h1234;
        #1;
        check("post_hazard_if_ready", {31'd0, bus.if_ready_o}, 32'd1);
        push(32'h10C, 32'h0020_81B3, 32'h11, 32'h1234, 32'd0, 5'd3, 1'b1, 1'b0);
        tick();
        clear_ctx();

        // LW x0 in EX must not stall ADD x5,x0,x0; x0 reads as zero
        send(32'h0000_02B3, 32'h110);
        ex_we = 1'b1; ex_is_load = 1'b1; ex_waddr = 5'd0; ex_wdata = 32'h5A;
        rf_rdata_a = 32'h55; rf_rdata_b = 32'h66;
        #1;
        check("x0_load_no_stall", {31'd0, bus.if_ready_o}, 32'd1);
        push(32'h110, 32'h0000_02B3, 32'd0, 32'd0, 32'd0, 5'd5, 1'b1, 1'b0);
        tick();
        clear_ctx();

        // ADD x0,x1,x1: no write enable
        send(32'h0010_8033, 32'h114);
        rf_rdata_a = 32'h77; rf_rdata_b = 32'h77;
        push(32'h114, 32'h0010_8033, 32'h77, 32'h77, 32'd0, 5'd0, 1'b0, 1'b0);
        tick();
        clear_ctx();

        // BEQ x1,x2,-8 (B imm, bit0 zero)
        send(32'hFE20_8CE3, 32'h118);
        rf_rdata_a = 32'h1; rf_rdata_b = 32'h2;
        push(32'h118, 32'hFE20_8CE3, 32'h1, 32'h2, 32'hFFFF_FFF8, 5'd25, 1'b0, 1'b0);
        tick();
        clear_ctx();

        // SW x2,-4(x1) (S imm)
        send(32'hFE20_AE23, 32'h11C);
        rf_rdata_a = 32'h3; rf_rdata_b = 32'h4;
        push(32'h11C, 32'hFE20_AE23, 32'h3, 32'h4, 32'hFFFF_FFFC, 5'd28, 1'b0, 1'b0);
        tick();
        clear_ctx();

        // JAL x1,+2048 (J imm), LUI x7,0x80000 (U imm), all-ones illegal word
        send(32'h0010_00EF, 32'h120);
        push(32'h120, 32'h0010_00EF, 32'd0, 32'd0, 32'h0000_0800, 5'd1, 1'b1, 1'b0);
        tick();
        send(32'h8000_03B7, 32'h124);
        push(32'h124, 32'h8000_03B7, 32'd0, 32'd0, 32'h8000_0000, 5'd7, 1'b1, 1'b0);
        tick();
        send(32'hFFFF_FFFF, 32'h128);
        push(32'h128, 32'hFFFF_FFFF, 32'd0, 32'd0, 32'd0, 5'd31, 1'b0, 1'b1);
        tick();

        // Back-to-back beats at full throughput
        bus.if_valid_i = 1'b1; bus.if_instr_i = 32'h0010_0093; bus.if_pc_i = 32'h200;
        tick();
        push(32'h200, 32'h0010_0093, 32'd0, 32'd0, 32'd1, 5'd1, 1'b1, 1'b0);
        bus.if_instr_i = 32'h0020_0113; bus.if_pc_i = 32'h204;
        #1;
        check("tput_if_ready_1", {31'd0, bus.if_ready_o}, 32'd1);
        tick();
        push(32'h204, 32'h0020_0113, 32'd0, 32'd0, 32'd2, 5'd2, 1'b1, 1'b0);
        bus.if_instr_i = 32'h0030_0193; bus.if_pc_i = 32'h208;
        #1;
        check("tput_if_ready_2", {31'd0, bus.if_ready_o}, 32'd1);
        check("tput_id_valid",   {31'd0, bus.id_valid_o}, 32'd1);
        tick();
        push(32'h208, 32'h0030_0193, 32'd0, 32'd0, 32'd3, 5'd3, 1'b1, 1'b0);
        bus.if_valid_i = 1'b0;
        tick();
        tick();

        // Backpressure: ID/EX holds, slot full, no acceptance
        bus.id_ready_i = 1'b0;
        send(32'h0010_0093, 32'h300);
        push(32'h300, 32'h0010_0093, 32'd0, 32'd0, 32'd1, 5'd1, 1'b1, 1'b0);
        tick();
        send(32'h0020_0113, 32'h304);
        push(32'h304, 32'h0020_0113, 32'd0, 32'd0, 32'd2, 5'd2, 1'b1, 1'b0);
        for (int i = 0; i < 3; i++) begin
            tick();
            check("bp_id_valid", {31'd0, bus.id_valid_o}, 32'd1);
            check("bp_id_pc",    bus.id_pc_o,    32'h300);
            check("bp_id_instr", bus.id_instr_o, 32'h0010_0093);
            check("bp_if_ready", {31'd0, bus.if_ready_o}, 32'd0);
        end
        bus.id_ready_i = 1'b1;
        tick();
        check("bp_release_pc", bus.id_pc_o, 32'h304);
        tick();

        // Flush with ID/EX valid, slot full and a beat presented
        bus.id_ready_i = 1'b0;
        send(32'h0020_0113, 32'h400);
        tick();
        send(32'h0030_0193, 32'h404);
        bus.if_valid_i = 1'b1; bus.if_instr_i = 32'h0050_0093; bus.if_pc_i = 32'h408;
        flush = 1'b1;
        tick();
        flush = 1'b0;
        bus.if_valid_i = 1'b0;
        bus.id_ready_i = 1'b1;
        check("flush_id_valid", {31'd0, bus.id_valid_o}, 32'd0);
        check("flush_slot_empty", {31'd0, bus.if_ready_o}, 32'd1);
        for (int i = 0; i < 3; i++) begin
            tick();
            check("flush_no_issue", {31'd0, bus.id_valid_o}, 32'd0);
        end

        // Reset while stalled on a load-use with ID/EX held
        bus.id_ready_i = 1'b0;
        send(32'h0010_0093, 32'h500);
        tick();
        send(32'h0020_81B3, 32'h504);
        ex_we = 1'b1; ex_is_load = 1'b1; ex_waddr = 5'd2;
        #1;
        check("rst_stall_if_ready", {31'd0, bus.if_ready_o}, 32'd0);
        rst = 1'b1;
        tick();
        check("midrst_id_valid", {31'd0, bus.id_valid_o}, 32'd0);
        check("midrst_if_ready", {31'd0, bus.if_ready_o}, 32'd1);
        check("midrst_id_pc",    bus.id_pc_o,   32'd0);
        check("midrst_id_op_a",  bus.id_op_a_o, 32'd0);
        rst = 1'b0;
        clear_ctx();
        bus.id_ready_i = 1'b1;
        tick();
        check("postrst_id_valid", {31'd0, bus.id_valid_o}, 32'd0);

        // Recovery after reset
        send(32'h0050_0093, 32'h600);
        push(32'h600, 32'h0050_0093, 32'd0, 32'd0, 32'd5, 5'd1, 1'b1, 1'b0);
        tick();

        for (int i = 0; i < 20 && sb.size() != 0; i++) begin
            tick();
        end
        check("scoreboard_drained", sb.size(), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/decode_stage.md
Name: decode_stage

Overview:
- Instruction-decode / operand-fetch stage of the RV32I pipeline, between fetch and execute.
- Buffers one fetched instruction, drives the register-file read ports, and resolves operands by bypassing from EX and WB.
- Detects load-use hazards and stalls for them, generates the immediate, and registers the result into the ID/EX pipeline register.
- Uses valid/ready handshakes on both sides.

Parameters:
- XLEN, 32, data/PC width
- ADDR_WIDTH, 5, register index width

Ports:
- clk  in  1  clock
- rst  in  1  reset; synchronous, active-high
- if_valid_i  in  1  fetch beat valid
- if_ready_o  out  1  stage can accept fetch beat
- if_instr_i  in  32  instruction word
- if_pc_i  in  XLEN  instruction PC
- rf_raddr_a_o  out  ADDR_WIDTH  rs1 index to register file
- rf_raddr_b_o  out  ADDR_WIDTH  rs2 index to register file
- rf_rdata_a_i  in  XLEN  rs1 data, combinational
- rf_rdata_b_i  in  XLEN  rs2 data, combinational
- ex_we_i  in  1  instruction in EX writes rd
- ex_waddr_i  in  ADDR_WIDTH  EX destination
- ex_wdata_i  in  XLEN  EX ALU result
- ex_is_load_i  in  1  EX instruction is a load; data not yet available
- wb_we_i  in  1  register-file write enable this cycle
- wb_waddr_i  in  ADDR_WIDTH  WB destination
- wb_wdata_i  in  XLEN  WB data
- flush_i  in  1  kill in-flight decode/ID-EX contents (taken branch/jump)
- id_valid_o  out  1  ID/EX register valid
- id_ready_i  in  1  EX accepts ID/EX contents
- id_pc_o  out  XLEN  registered PC
- id_instr_o  out  32  registered instruction
- id_op_a_o  out  XLEN  resolved rs1 value
- id_op_b_o  out  XLEN  resolved rs2 value
- id_imm_o  out  XLEN  sign-extended immediate
- id_rd_o  out  ADDR_WIDTH  destination index
- id_rd_we_o  out  1  rd write enable; 0 if rd==0 or the format has no rd
- id_illegal_o  out  1  unknown opcode

Behaviour:
- Reset: slot_valid=0, id_valid_o=0, all ID/EX data outputs 0. Takes effect in any state, including mid-stall.
- Internal IF/ID slot (instr, pc, slot_valid).
- Two-state FSM per slot: EMPTY/FULL.
- advance = slot_valid && !hazard && (!id_valid_o || id_ready_i).
- if_ready_o = !slot_valid || advance; combinational, does not depend on if_valid_i.
- Slot loads on if_valid_i && if_ready_o. Otherwise slot_valid clears on advance.
- On advance, the ID/EX register loads decoded data and id_valid_o=1.
- If no advance and id_ready_i=1, id_valid_o=0 (bubble). If no advance and id_ready_i=0, ID/EX holds all values stable.
- Latency: a fetch beat accepted in cycle N appears on id_* in N+1 when there is no hazard or backpressure. Throughput is 1 instruction/cycle.
- rf_raddr_a/b_o = slot instr[19:15] / [24:20]; driven even when the slot is empty.
- Operand resolution per source, first match wins:
  - index==0 -> 0
  - ex_we_i && ex_waddr_i==index && !ex_is_load_i -> ex_wdata_i
  - wb_we_i && wb_waddr_i==index -> wb_wdata_i; the register-file write is not yet visible on the same cycle
  - else rf_rdata
- Register use by opcode:
  - LUI, AUIPC, JAL: no rs
  - JALR, LOAD, OP-IMM: rs1
  - BRANCH, STORE, OP: rs1 and rs2
  - unknown: both (conservative), imm=0, id_illegal_o=1
- hazard = slot_valid && ex_we_i && ex_is_load_i && ex_waddr_i!=0 && ex_waddr_i matches a used rs. This gives a 1-cycle stall per load-use; the slot holds.
- Immediate formats:
  - I: OP-IMM, LOAD, JALR
  - S: STORE
  - B: BRANCH
  - U: LUI, AUIPC
  - J: JAL
  - All sign-extended from instr[31]; B and J have bit0=0.
- flush_i: next cycle slot_valid=0 and id_valid_o=0. A fetch beat presented in the flush cycle is dropped. Flush overrides advance, hazard and backpressure.
- Simultaneous slot load and advance (full throughput) is legal. The new beat replaces the old slot contents in the same edge.

Decomposition:
- riscv_pkg:
  - opcode localparams (OPC_LUI, OPC_AUIPC, OPC_JAL, OPC_JALR, OPC_BRANCH, OPC_LOAD, OPC_STORE, OPC_OP_IMM, OPC_OP)
  - imm_type_e enum {IMM_I, IMM_S, IMM_B, IMM_U, IMM_J, IMM_NONE}
  - field-slice constants
- Sub-module imm_gen: combinational; takes instr and imm_type_e, outputs XLEN immediate. Reused later by the branch unit.

Test Plan:
- Reset, then ADDI x1,x0,5 (0x00500093) with pc=0x100 -> next cycle id_valid_o=1, id_imm_o=5, id_rd_o=1, id_rd_we_o=1, id_op_a_o=0.
- ADD x3,x1,x2 with ex_we=1, ex_waddr=1, ex_wdata=0xAA, wb_we=1, wb_waddr=1, wb_wdata=0xBB, wb_waddr=2 absent, rf_rdata_b=0x22 -> id_op_a_o=0xAA (EX wins), id_op_b_o=0x22.
- ADD x3,x1,x2 while EX is LW x2 (ex_is_load=1, ex_waddr=2) -> if_ready_o=0, id_valid_o=0 for 1 cycle. Next cycle with wb_we=1, wb_waddr=2, wb_wdata=0x1234 -> id_op_b_o=0x1234.
- LW x0 in EX, ADD x5,x0,x0 in slot -> no stall, both operands 0. ADD x0,x1,x1 -> id_rd_we_o=0.
- id_ready_i=0 for 3 cycles with a valid ID/EX and a full slot -> id_* stable, if_ready_o=0. Release -> next instruction issues on the following cycle.
- flush_i with slot full and id_valid_o=1 while if_valid_i=1 -> next cycle id_valid_o=0, slot empty, the dropped beat never appears. rst asserted during a stall -> all valid outputs 0 the next cycle.
